// File: rtl/chirp_pkg.sv
// Shared widths, FSM state encoding and config record for the chirp ramp generator.
// The DDS side takes PHASE_BITS from here so both ends agree on the FTW width.
package chirp_pkg;

   localparam int PHASE_BITS = 32;
   localparam int FRAC_BITS  = 32;
   localparam int LEN_BITS   = 20;
   localparam int CNT_BITS   = 16;
   localparam int ACC_W      = PHASE_BITS + FRAC_BITS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DWELL
   } chirp_state_t;

   typedef struct packed {
      logic [PHASE_BITS-1:0] f_start;
      logic [ACC_W-1:0]      f_step;
      logic [LEN_BITS-1:0]   len;
      logic [LEN_BITS-1:0]   dwell;
      logic [CNT_BITS-1:0]   count;
   } chirp_cfg_t;

   // A zero-length chirp still emits one sample.
   function automatic logic [LEN_BITS-1:0] eff_len(input logic [LEN_BITS-1:0] len);
      return (len == '0) ? LEN_BITS'(1) : len;
   endfunction

endpackage

// File: rtl/chirp_freq_acc.sv
// Loadable fixed-point frequency accumulator; FTW is the integer part of the Q(PHASE).(FRAC) value.
// Wraps modulo 2^ACC_W; neg subtracts the step for down legs.
module chirp_freq_acc
   import chirp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  logic [PHASE_BITS-1:0] load_ftw,
   input  logic                  en,
   input  logic                  neg,
   input  logic [ACC_W-1:0]      step,
   output logic [PHASE_BITS-1:0] ftw
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] delta;

   assign delta = neg ? (~step + ACC_W'(1)) : step;

   always_ff @(posedge clk) begin
      if (!rst || clr)
         acc <= '0;
      else if (load)
         acc <= {load_ftw, {FRAC_BITS{1'b0}}};
      else if (en)
         acc <= acc + delta;
   end

   assign ftw = acc[ACC_W-1:FRAC_BITS];

endmodule

// File: rtl/chirp_ramp_gen.sv
// Chirp sweep controller: emits one FTW per clock, sequencing N chirps with dwell gaps.
// Define CHIRP_TRIANGLE_EN for up/down (triangle) chirps; default build is sawtooth.
module chirp_ramp_gen
   import chirp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   input  logic [PHASE_BITS-1:0] cfg_f_start,
   input  logic [ACC_W-1:0]      cfg_f_step,
   input  logic [LEN_BITS-1:0]   cfg_len,
   input  logic [LEN_BITS-1:0]   cfg_dwell,
   input  logic [CNT_BITS-1:0]   cfg_count,
   input  logic                  start,
   input  logic                  abort,
   output logic [PHASE_BITS-1:0] ftw_out,
   output logic                  ftw_valid,
   output logic                  phase_rst,
   output logic                  busy,
   output logic                  done
);

   chirp_state_t state, state_nxt;
   chirp_cfg_t   cfg_in, cfg_src, shadow, active;

   logic [LEN_BITS-1:0]   sample_cnt, dwell_cnt, len_e;
   logic [CNT_BITS-1:0]   chirp_cnt;
   logic [PHASE_BITS-1:0] acc_ftw, load_ftw;
   logic                  phase_rst_q, done_q;
   logic                  leg, leg_end, chirp_end, more;
   logic                  first_smp, acc_en, leg_turn, dwell_go, fin;

   assign cfg_in  = {cfg_f_start, cfg_f_step, cfg_len, cfg_dwell, cfg_count};
   // Same-cycle cfg_valid and start: the burst takes the fresh values.
   assign cfg_src = cfg_valid ? cfg_in : shadow;

   assign len_e   = eff_len(active.len);
   assign leg_end = (sample_cnt == len_e);
   assign more    = (active.count == '0) || (chirp_cnt != active.count);

`ifdef CHIRP_TRIANGLE_EN
   assign chirp_end = leg_end && leg;

   always_ff @(posedge clk) begin
      if (!rst)
         leg <= 1'b0;
      else if (first_smp)
         leg <= 1'b0;
      else if (leg_turn)
         leg <= 1'b1;
   end
`else
   assign chirp_end = leg_end;
   assign leg       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      first_smp = 1'b0;
      acc_en    = 1'b0;
      leg_turn  = 1'b0;
      dwell_go  = 1'b0;
      fin       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SWEEP;
               first_smp = 1'b1;
            end
         end
         ST_SWEEP: begin
            if (chirp_end) begin
               if (!more) begin
                  state_nxt = ST_IDLE;
                  fin       = 1'b1;
               end else if (active.dwell != '0) begin
                  state_nxt = ST_DWELL;
                  dwell_go  = 1'b1;
               end else begin
                  first_smp = 1'b1;
               end
            end else if (leg_end) begin
               leg_turn = 1'b1;
            end else begin
               acc_en = 1'b1;
            end
         end
         ST_DWELL: begin
            if (dwell_cnt == active.dwell) begin
               state_nxt = ST_SWEEP;
               first_smp = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Abort overrides every transition, including a start in IDLE.
      if (abort) begin
         state_nxt = ST_IDLE;
         first_smp = 1'b0;
         acc_en    = 1'b0;
         leg_turn  = 1'b0;
         dwell_go  = 1'b0;
         fin       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow      <= '0;
         active      <= '0;
         sample_cnt  <= '0;
         dwell_cnt   <= '0;
         chirp_cnt   <= '0;
         phase_rst_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (cfg_valid)
            shadow <= cfg_in;
         phase_rst_q <= first_smp;
         done_q      <= fin;

         if (state == ST_IDLE && first_smp) begin
            active    <= cfg_src;
            chirp_cnt <= CNT_BITS'(1);
         end else if (first_smp) begin
            chirp_cnt <= chirp_cnt + CNT_BITS'(1);
         end

         if (first_smp || leg_turn)
            sample_cnt <= LEN_BITS'(1);
         else if (acc_en)
            sample_cnt <= sample_cnt + LEN_BITS'(1);

         if (dwell_go)
            dwell_cnt <= LEN_BITS'(1);
         else if (state == ST_DWELL)
            dwell_cnt <= dwell_cnt + LEN_BITS'(1);
      end
   end

   assign load_ftw = (state == ST_IDLE) ? cfg_src.f_start : active.f_start;

   chirp_freq_acc u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort),
      .load     (first_smp),
      .load_ftw (load_ftw),
      .en       (acc_en | leg_turn),
      .neg      (leg | leg_turn),
      .step     (active.f_step),
      .ftw      (acc_ftw)
   );

   assign ftw_valid = (state == ST_SWEEP);
   assign ftw_out   = ftw_valid ? acc_ftw : '0;
   assign phase_rst = phase_rst_q;
   assign done      = done_q;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_chirp_ramp_gen.sv
// Directed bench for chirp_ramp_gen: closed-form sweep model feeds a per-cycle compare process,
// with literal expectations on captured samples pinning the model.
module tb_chirp_ramp_gen;
   import chirp_pkg::*;

   logic                  clk, rst, cfg_valid, start, abort;
   logic [PHASE_BITS-1:0] cfg_f_start;
   logic [ACC_W-1:0]      cfg_f_step;
   logic [LEN_BITS-1:0]   cfg_len, cfg_dwell;
   logic [CNT_BITS-1:0]   cfg_count;
   logic [PHASE_BITS-1:0] ftw_out;
   logic                  ftw_valid, phase_rst, busy, done;

   typedef struct {
      logic        v;
      logic [31:0] f;
      logic        pr;
      logic        d;
      logic        b;
   } smp_t;

   localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
   localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
   localparam logic [63:0] MONE = 64'hFFFF_FFFF_0000_0000;

   smp_t exp_q[$];
   smp_t obs_q[$];
   smp_t idle_s, e_s, a_s;
   int   n_assert = 0;
   int   n_fail   = 0;

   chirp_ramp_gen dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_f_start (cfg_f_start),
      .cfg_f_step  (cfg_f_step),
      .cfg_len     (cfg_len),
      .cfg_dwell   (cfg_dwell),
      .cfg_count   (cfg_count),
      .start       (start),
      .abort       (abort),
      .ftw_out     (ftw_out),
      .ftw_valid   (ftw_valid),
      .phase_rst   (phase_rst),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sample k of a chirp is start + k*step on the up leg; the down leg mirrors from the last up value.
   task automatic model_burst(input logic [31:0] fs, input logic [63:0] st, input int len,
                              input int dwell, input int count, input int limit);
      int le, spc, pushed, c;
      logic [63:0] base, val;
      smp_t s;
      le = (len == 0) ? 1 : len;
`ifdef CHIRP_TRIANGLE_EN
      spc = 2 * le;
`else
      spc = le;
`endif
      pushed = 0;
      c      = 0;
      base   = {fs, 32'h0};
      while (count == 0 || c < count) begin
         for (int i = 0; i < spc; i++) begin
            if (i < le) val = base + 64'(i) * st;
            else        val = base + 64'(le - 1) * st - 64'(i - le + 1) * st;
            s.v = 1'b1; s.f = val[63:32]; s.pr = (i == 0); s.d = 1'b0; s.b = 1'b1;
            exp_q.push_back(s);
            pushed++;
            if (limit > 0 && pushed >= limit) return;
         end
         c++;
         if (count == 0 || c < count) begin
            for (int k = 0; k < dwell; k++) begin
               s.v = 1'b0; s.f = 32'h0; s.pr = 1'b0; s.d = 1'b0; s.b = 1'b1;
               exp_q.push_back(s);
               pushed++;
               if (limit > 0 && pushed >= limit) return;
            end
         end
      end
      s.v = 1'b0; s.f = 32'h0; s.pr = 1'b0; s.d = 1'b1; s.b = 1'b0;
      exp_q.push_back(s);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e_s = exp_q.pop_front();
            a_s.v = ftw_valid; a_s.f = ftw_out; a_s.pr = phase_rst; a_s.d = done; a_s.b = busy;
            obs_q.push_back(a_s);
            n_assert++;
            if (a_s.v !== e_s.v || a_s.f !== e_s.f || a_s.pr !== e_s.pr ||
                a_s.d !== e_s.d || a_s.b !== e_s.b) begin
               n_fail++;
               $display("FAIL cycle t=%0t: got v=%b f=%h pr=%b d=%b b=%b, want v=%b f=%h pr=%b d=%b b=%b",
                        $time, a_s.v, a_s.f, a_s.pr, a_s.d, a_s.b, e_s.v, e_s.f, e_s.pr, e_s.d, e_s.b);
            end
         end
      end
   end

   task automatic chk_lit(input string name, input int idx, input logic [31:0] f,
                          input logic v, input logic pr, input logic d);
      n_assert++;
      if (idx >= obs_q.size()) begin
         n_fail++;
         $display("FAIL %s: sample %0d missing, only %0d captured", name, idx, obs_q.size());
      end else if (obs_q[idx].f !== f || obs_q[idx].v !== v || obs_q[idx].pr !== pr ||
                   obs_q[idx].d !== d) begin
         n_fail++;
         $display("FAIL %s: got f=%h v=%b pr=%b d=%b, want f=%h v=%b pr=%b d=%b", name,
                  obs_q[idx].f, obs_q[idx].v, obs_q[idx].pr, obs_q[idx].d, f, v, pr, d);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      n_assert++;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected samples left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic set_cfg(input logic [31:0] fs, input logic [63:0] st, input int len,
                          input int dw, input int cnt);
      cfg_f_start = fs;
      cfg_f_step  = st;
      cfg_len     = LEN_BITS'(len);
      cfg_dwell   = LEN_BITS'(dw);
      cfg_count   = CNT_BITS'(cnt);
   endtask

   // Finite burst loaded with cfg_valid in the start cycle; called at a falling edge.
   task automatic burst(input logic [31:0] fs, input logic [63:0] st, input int len,
                        input int dw, input int cnt);
      set_cfg(fs, st, len, dw, cnt);
      cfg_valid = 1'b1;
      start     = 1'b1;
      obs_q.delete();
      model_burst(fs, st, len, dw, cnt, 0);
      exp_q.push_back(idle_s);
      @(negedge clk);
      cfg_valid = 1'b0;
      start     = 1'b0;
      drain();
   endtask

   initial begin
      idle_s.v = 1'b0; idle_s.f = 32'h0; idle_s.pr = 1'b0; idle_s.d = 1'b0; idle_s.b = 1'b0;

      // Reset held with start and cfg_valid asserted: stays idle, shadow stays clear.
      rst = 1'b0; abort = 1'b0; start = 1'b1; cfg_valid = 1'b1;
      set_cfg(32'hDEAD_BEEF, ONE, 5, 2, 3);
      for (int i = 0; i < 5; i++) exp_q.push_back(idle_s);
      repeat (5) @(negedge clk);
      rst = 1'b1; cfg_valid = 1'b0;

      // Start from cleared shadow: all-zero config, len 0 acts as 1, count 0 is continuous.
      obs_q.delete();
      model_burst(32'h0, 64'h0, 0, 0, 0, 2);
      exp_q.push_back(idle_s);
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      drain();
      chk_lit("zero_cfg_s0", 0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_lit("zero_cfg_s1", 1, 32'h0, 1'b1, 1'b1, 1'b0);

      burst(32'h1000_0000, ONE, 4, 0, 1);
      chk_lit("ramp_s0", 0, 32'h1000_0000, 1'b1, 1'b1, 1'b0);
      chk_lit("ramp_s1", 1, 32'h1000_0001, 1'b1, 1'b0, 1'b0);
      chk_lit("ramp_s3", 3, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
`ifndef CHIRP_TRIANGLE_EN
      chk_lit("ramp_done", 4, 32'h0, 1'b0, 1'b0, 1'b1);
`else
      chk_lit("tri_turn", 4, 32'h1000_0002, 1'b1, 1'b0, 1'b0);
`endif

      burst(32'h1000_0000, HALF, 4, 0, 1);
      chk_lit("half_s1", 1, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
      chk_lit("half_s2", 2, 32'h1000_0001, 1'b1, 1'b0, 1'b0);
      chk_lit("half_s3", 3, 32'h1000_0001, 1'b1, 1'b0, 1'b0);

      burst(32'h0000_0100, ONE, 3, 2, 2);
`ifndef CHIRP_TRIANGLE_EN
      chk_lit("dwell_gap", 3, 32'h0, 1'b0, 1'b0, 1'b0);
      chk_lit("dwell_c2", 5, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
      chk_lit("dwell_done", 8, 32'h0, 1'b0, 1'b0, 1'b1);
`endif

      burst(32'hFFFF_FFFE, ONE, 4, 0, 1);
      chk_lit("wrap_s1", 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      chk_lit("wrap_s2", 2, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      chk_lit("wrap_s3", 3, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

      burst(32'h0000_0010, MONE, 3, 0, 1);
      chk_lit("down_s2", 2, 32'h0000_000E, 1'b1, 1'b0, 1'b0);

      burst(32'h0000_0500, ONE, 2, 0, 2);
`ifndef CHIRP_TRIANGLE_EN
      chk_lit("b2b_c2", 2, 32'h0000_0500, 1'b1, 1'b1, 1'b0);
`endif

`ifdef CHIRP_TRIANGLE_EN
      burst(32'h4000_0000, ONE, 3, 0, 1);
      chk_lit("tri_s2", 2, 32'h4000_0002, 1'b1, 1'b0, 1'b0);
      chk_lit("tri_s3", 3, 32'h4000_0001, 1'b1, 1'b0, 1'b0);
      chk_lit("tri_s5", 5, 32'h3FFF_FFFF, 1'b1, 1'b0, 1'b0);
      chk_lit("tri_done", 6, 32'h0, 1'b0, 1'b0, 1'b1);
`endif

      // Continuous burst: mid-burst cfg write and start are ignored; abort stops it next cycle.
      set_cfg(32'h2000_0000, ONE, 3, 1, 0);
      cfg_valid = 1'b1; start = 1'b1;
      obs_q.delete();
      model_burst(32'h2000_0000, ONE, 3, 1, 0, 10);
      exp_q.push_back(idle_s);
      @(negedge clk); cfg_valid = 1'b0; start = 1'b0;
      @(negedge clk); cfg_f_start = 32'h3000_0000; cfg_valid = 1'b1; start = 1'b1;
      @(negedge clk); cfg_valid = 1'b0; start = 1'b0;
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      drain();
      chk_lit("abort_idle", 10, 32'h0, 1'b0, 1'b0, 1'b0);

      // Restart without cfg_valid picks up the shadow written mid-burst.
      start = 1'b1;
      obs_q.delete();
      model_burst(32'h3000_0000, ONE, 3, 1, 0, 4);
      exp_q.push_back(idle_s);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk); abort = 1'b0; start = 1'b0;
      drain();
      chk_lit("restart_s0", 0, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
      chk_lit("restart_s1", 1, 32'h3000_0001, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
